// File: rtl/ex_result_stage.sv
// EX/MEM result register for the 16-bit WISC datapath: result select, N/Z/V flags,
// stall/flush control and a sticky error bit for malformed RED results.
module ex_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  op,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic [15:0] red_sum,
    input  logic [3:0]  dst_reg,
    input  logic        wr_en,
    output logic        out_valid,
    output logic [15:0] out_result,
    output logic [3:0]  out_dst,
    output logic        out_wr_en,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        red_err
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_RED = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic        r_valid;
    logic [15:0] r_result;
    logic [3:0]  r_dst;
    logic        r_wr_en;
    logic        r_n;
    logic        r_z;
    logic        r_v;
    logic        r_red_err;

    logic [15:0] w_sel;
    logic        w_bubble;
    logic        w_zero;
    logic        w_red_bad;

    assign w_sel     = (op == OP_RED) ? red_sum : alu_result;
    assign w_zero    = (w_sel == 16'h0000);
    // An idle, unstalled cycle loads a bubble exactly like a flush.
    assign w_bubble  = flush || (!stall && !in_valid);
    assign w_red_bad = (red_sum[15:12] != {4{red_sum[11]}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_result  <= 16'h0000;
            r_dst     <= 4'h0;
            r_wr_en   <= 1'b0;
            r_n       <= 1'b0;
            r_z       <= 1'b0;
            r_v       <= 1'b0;
            r_red_err <= 1'b0;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (!stall) begin
            r_valid  <= 1'b1;
            r_result <= w_sel;
            r_dst    <= dst_reg;
            r_wr_en  <= wr_en;
            case (op)
                OP_ADD, OP_SUB: begin
                    r_z <= w_zero;
                    r_n <= w_sel[15];
                    r_v <= alu_ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    r_z <= w_zero;
                end
                default: begin
                end
            endcase
            if (op == OP_RED && w_red_bad) begin
                r_red_err <= 1'b1;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_dst    = r_dst;
    assign out_wr_en  = r_wr_en;
    assign flag_n     = r_n;
    assign flag_z     = r_z;
    assign flag_v     = r_v;
    assign red_err    = r_red_err;

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: directed vectors push hand-computed expected
// register state; a monitor pops and compares one entry after every clock edge.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [15:0] alu_result = 16'h0000;
    logic        alu_ovfl = 1'b0;
    logic [15:0] red_sum = 16'h0000;
    logic [3:0]  dst_reg = 4'h0;
    logic        wr_en = 1'b0;
    logic        out_valid;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic        out_wr_en;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        red_err;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] result;
        logic [3:0]  dst;
        logic        wr;
        logic [2:0]  nzv;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    string name_q[$];

    ex_result_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .op(op), .alu_result(alu_result), .alu_ovfl(alu_ovfl), .red_sum(red_sum),
        .dst_reg(dst_reg), .wr_en(wr_en), .out_valid(out_valid), .out_result(out_result),
        .out_dst(out_dst), .out_wr_en(out_wr_en), .flag_n(flag_n), .flag_z(flag_z),
        .flag_v(flag_v), .red_err(red_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.valid  = out_valid;
        a.result = out_result;
        a.dst    = out_dst;
        a.wr     = out_wr_en;
        a.nzv    = {flag_n, flag_z, flag_v};
        a.err    = red_err;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = actual();
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("FAIL %s: got v=%0b res=%h dst=%h wr=%0b nzv=%b err=%0b, want v=%0b res=%h dst=%h wr=%0b nzv=%b err=%0b",
                     name, a.valid, a.result, a.dst, a.wr, a.nzv, a.err,
                     e.valid, e.result, e.dst, e.wr, e.nzv, e.err);
        end
    endtask

    // Monitor: compare after every edge that has an expectation pending.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input string name,
                       input logic v, input logic s, input logic f, input logic [3:0] o,
                       input logic [15:0] alu, input logic ov, input logic [15:0] red,
                       input logic [3:0] d, input logic w,
                       input logic ev, input logic [15:0] eres, input logic [3:0] ed,
                       input logic ew, input logic [2:0] enzv, input logic eerr);
        exp_t e;
        in_valid = v; stall = s; flush = f; op = o;
        alu_result = alu; alu_ovfl = ov; red_sum = red; dst_reg = d; wr_en = w;
        e.valid = ev; e.result = eres; e.dst = ed; e.wr = ew; e.nzv = enzv; e.err = eerr;
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t z;
        z = '0;
        @(negedge clk);
        check("reset_init", z);
        rst = 1'b0;

        //   name          v s f op     alu      ov red      d  w   ev eres     ed ew nzv   err
        cyc("add_zero",    1,0,0,4'h0, 16'h0000,1,16'h0000,3,1,  1,16'h0000, 3,1,3'b011,0);
        cyc("xor",         1,0,0,4'h2, 16'h8001,0,16'h0000,4,1,  1,16'h8001, 4,1,3'b001,0);
        cyc("red_ok",      1,0,0,4'h3, 16'h1234,0,16'hFF80,5,1,  1,16'hFF80, 5,1,3'b001,0);
        cyc("red_bad",     1,0,0,4'h3, 16'h1234,0,16'h0F80,5,1,  1,16'h0F80, 5,1,3'b001,1);
        cyc("add_sticky1", 1,0,0,4'h0, 16'h0010,0,16'h0000,6,1,  1,16'h0010, 6,1,3'b000,1);
        cyc("add_sticky2", 1,0,0,4'h0, 16'hFFFF,0,16'h0000,6,1,  1,16'hFFFF, 6,1,3'b100,1);
        cyc("idle_bubble", 0,0,0,4'h0, 16'h0000,1,16'h0000,2,1,  0,16'hFFFF, 6,0,3'b100,1);
        cyc("sub",         1,0,0,4'h1, 16'h0005,0,16'h0000,7,1,  1,16'h0005, 7,1,3'b000,1);
        cyc("stall1",      1,1,0,4'h0, 16'h0000,1,16'h0000,8,0,  1,16'h0005, 7,1,3'b000,1);
        cyc("stall2",      1,1,0,4'h0, 16'h0000,1,16'h0000,8,0,  1,16'h0005, 7,1,3'b000,1);
        cyc("stall3",      1,1,0,4'h0, 16'h0000,1,16'h0000,8,0,  1,16'h0005, 7,1,3'b000,1);
        cyc("stall_flush", 1,1,1,4'h0, 16'h0000,1,16'h0000,8,0,  0,16'h0005, 7,0,3'b000,1);
        cyc("held_accept", 1,0,0,4'h0, 16'h0000,1,16'h0000,8,0,  1,16'h0000, 8,0,3'b011,1);
        cyc("flush_only",  1,0,1,4'h0, 16'h8000,0,16'h0000,9,1,  0,16'h0000, 8,0,3'b011,1);
        cyc("non_alu",     1,0,0,4'h8, 16'h8000,0,16'h0000,9,1,  1,16'h8000, 9,1,3'b011,1);
        cyc("paddsb",      1,0,0,4'h7, 16'h0000,0,16'h0000,9,1,  1,16'h0000, 9,1,3'b011,1);
        cyc("sra",         1,0,0,4'h5, 16'h8000,0,16'h0000,1,1,  1,16'h8000, 1,1,3'b001,1);
        cyc("ror_zero",    1,0,0,4'h6, 16'h0000,0,16'h0000,2,1,  1,16'h0000, 2,1,3'b011,1);
        cyc("sll",         1,0,0,4'h4, 16'h0001,0,16'h0000,2,1,  1,16'h0001, 2,1,3'b001,1);
        cyc("add_neg",     1,0,0,4'h0, 16'h8000,1,16'h0000,3,1,  1,16'h8000, 3,1,3'b101,1);
        cyc("xor_zero",    1,0,0,4'h2, 16'h0000,0,16'h0000,4,1,  1,16'h0000, 4,1,3'b111,1);

        // Asynchronous reset between edges while valid with all flags set.
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_reset", z);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_reset",  1,0,0,4'h0, 16'h0042,0,16'h0000,5,1,  1,16'h0042, 5,1,3'b000,0);

        repeat (3) @(posedge clk);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage result register and flag unit for the 16-bit WISC datapath. Sits directly downstream of the RED reduction unit and the main adder/logic/shift ALU. It selects the correct 16-bit result for the current opcode, updates the 3-bit condition flag register (N, Z, V) per opcode rules, and holds the EX/MEM pipeline register with stall and flush control. It also keeps a sticky diagnostic bit that flags a malformed RED result.

## Interface
Parameters:
- none (datapath fixed at 16 bits, opcode 4 bits, register index 4 bits)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX stage holds a real instruction this cycle
- stall  in  1  hold the EX/MEM register and flags unchanged
- flush  in  1  squash the EX-stage instruction by inserting a bubble
- op  in  4  opcode: ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111; other values are non-ALU
- alu_result  in  16  result from the adder/logic/shift ALU
- alu_ovfl  in  1  signed overflow from the ADD/SUB adder
- red_sum  in  16  result from the RED unit; only bits [11:0] are significant, and [15:12] must equal the replicated bit 11
- dst_reg  in  4  destination register index
- wr_en  in  1  instruction writes the register file
- out_valid  out  1  EX/MEM register holds a real instruction
- out_result  out  16  registered result
- out_dst  out  4  registered destination index
- out_wr_en  out  1  registered write enable, forced to 0 when out_valid=0
- flag_n, flag_z, flag_v  out  1 each  condition flags
- red_err  out  1  sticky error bit for a malformed RED result

## Operation
- Result selection: `sel = (op==RED) ? red_sum : alu_result`.
- An instruction is accepted in a cycle when `in_valid && !stall && !flush`.
- Priority is `rst` > `flush` > `stall` > accept.
- On flush:
  - out_valid becomes 0 and out_wr_en becomes 0.
  - out_result and out_dst keep their old values.
  - Flags and red_err are unchanged.
- On stall without flush: all registers hold.
- On accept:
  - out_valid becomes 1, out_result becomes sel, out_dst becomes dst_reg, out_wr_en becomes wr_en.
- When neither stall nor flush is asserted and in_valid=0, a bubble is loaded, the same as a flush.
- Flag update, applied only on accept:
  - ADD or SUB: Z = (sel==0), N = sel[15], V = alu_ovfl.
  - XOR, SLL, SRA or ROR: Z = (sel==0); N and V hold.
  - RED, PADDSB or any non-ALU opcode: all flags hold.
- red_err check:
  - Set on accept when op==RED and red_sum[15:12] != {4{red_sum[11]}}.
  - Cleared only by rst.

## Timing
- Reset values: out_valid=0, out_result=0, out_dst=0, out_wr_en=0, flag_n=0, flag_z=0, flag_v=0, red_err=0.
- Reset asserted mid-stream clears everything immediately, without waiting for a clock edge. The first accept after reset deassertion is on the next rising edge.
- Latency is one cycle. Inputs accepted on edge k appear on the outputs after edge k, and the flags reflect that instruction from the same edge.
- Flags are registered. A branch in the cycle after an accept sees the new flags; there is no combinational bypass.
- Back-to-back accepts are allowed every cycle (throughput of 1 per cycle).
- If stall is held for N cycles, the outputs are frozen for N cycles. The held instruction is accepted on the first edge where stall=0.
- flush and stall asserted in the same cycle: the flush wins and a bubble is loaded.

## Test plan
- Reset behaviour: assert rst asynchronously between clock edges while out_valid=1 and flags=3'b111 -> all outputs read 0 before the next edge.
- ADD: op=0000, alu_result=16'h0000, alu_ovfl=1 -> next cycle out_result=0, Z=1, N=0, V=1, out_valid=1.
- XOR: follow the ADD case with op=0010, alu_result=16'h8001 -> Z=0, N and V keep 0 and 1.
- RED: op=0011, red_sum=16'hFF80, alu_result=16'h1234 -> out_result=16'hFF80, flags unchanged, red_err=0.
- Malformed RED: repeat with red_sum=16'h0F80 -> red_err=1, and it stays 1 through the following accepted ADDs.
- Stall then flush:
  - Accept SUB with result 16'h0005, then hold stall for 3 cycles -> outputs frozen for 3 cycles.
  - Then assert stall and flush together -> out_valid=0, out_wr_en=0, flags unchanged.
